// File: rtl/vga_scan_fetch.sv
// Scan counters plus downscaled 1-bit frame fetch for the VGA sync chain.
// Owns x/y position, bank swapping at frame boundaries and the read-data pipeline.
module vga_scan_fetch #(
  parameter int H_AREA      = 800,
  parameter int H_LINE      = 1056,
  parameter int V_AREA      = 600,
  parameter int V_LINE      = 628,
  parameter int SCALE_SHIFT = 3,
  parameter int SRC_W       = 100,
  parameter int SRC_H       = 75,
  parameter int ADDR_W      = 13,
  parameter int MEM_LATENCY = 1
) (
  input  logic                        CLK_40,
  input  logic                        reset,
  input  logic                        pixel_clk,
  input  logic                        frame_ready,
  input  logic                        mem_rd_data,
  output logic [$clog2(H_LINE)-1:0]   x_pos,
  output logic [$clog2(V_LINE)-1:0]   y_pos,
  output logic                        frame_start,
  output logic                        mem_rd_en,
  output logic [ADDR_W:0]             mem_addr,
  output logic                        pixel_out,
  output logic                        pixel_valid,
  output logic                        bank_sel,
  output logic                        frame_ack
);

  localparam int XW = $clog2(H_LINE);
  localparam int YW = $clog2(V_LINE);
  localparam logic [ADDR_W-1:0] LAST_ROW_BASE = ADDR_W'((SRC_H - 1) * SRC_W);

  logic [XW-1:0]     x_reg;
  logic [YW-1:0]     y_reg;
  logic [ADDR_W-1:0] row_base_reg;
  logic              bank_reg;
  logic              hold_reg;

  logic x_last, y_last, active, step;

  assign x_last = (x_reg == XW'(H_LINE - 1));
  assign y_last = (y_reg == YW'(V_LINE - 1));
  assign active = (x_reg < XW'(H_AREA)) && (y_reg < YW'(V_AREA));
  assign step   = pixel_clk & ~reset;

  // Row base tracks (y >> SCALE_SHIFT) * SRC_W incrementally; it parks on the
  // last source row during vertical blanking so the address stays in range.
  always_ff @(posedge CLK_40) begin
    if (reset) begin
      x_reg        <= '0;
      y_reg        <= '0;
      row_base_reg <= '0;
      bank_reg     <= 1'b0;
    end else if (pixel_clk) begin
      if (x_last) begin
        x_reg <= '0;
        if (y_last) begin
          y_reg        <= '0;
          row_base_reg <= '0;
          if (frame_ready)
            bank_reg <= ~bank_reg;
        end else begin
          y_reg <= y_reg + 1'b1;
          if ((&y_reg[SCALE_SHIFT-1:0]) && (row_base_reg != LAST_ROW_BASE))
            row_base_reg <= row_base_reg + ADDR_W'(SRC_W);
        end
      end else begin
        x_reg <= x_reg + 1'b1;
      end
    end
  end

  assign x_pos       = x_reg;
  assign y_pos       = y_reg;
  assign bank_sel    = bank_reg;
  assign frame_start = step & x_last & y_last;
  assign frame_ack   = frame_start & frame_ready;
  assign mem_rd_en   = step & active;
  assign mem_addr    = {bank_reg, row_base_reg + ADDR_W'(x_reg >> SCALE_SHIFT)};

  // One {valid, active} stage per cycle of memory latency.
  genvar gi;
  generate
    for (gi = 0; gi < MEM_LATENCY; gi++) begin : g_pipe
      logic vld_reg, act_reg;
      logic vld_next, act_next;
      if (gi == 0) begin : g_head
        assign vld_next = step;
        assign act_next = step & active;
      end else begin : g_tail
        assign vld_next = g_pipe[gi-1].vld_reg;
        assign act_next = g_pipe[gi-1].act_reg;
      end
      always_ff @(posedge CLK_40) begin
        if (reset) begin
          vld_reg <= 1'b0;
          act_reg <= 1'b0;
        end else begin
          vld_reg <= vld_next;
          act_reg <= act_next;
        end
      end
    end
  endgenerate

  logic pipe_vld, pipe_act;
  assign pipe_vld    = g_pipe[MEM_LATENCY-1].vld_reg & ~reset;
  assign pipe_act    = g_pipe[MEM_LATENCY-1].act_reg;
  assign pixel_valid = pipe_vld;
  assign pixel_out   = pipe_vld ? (pipe_act & mem_rd_data) : hold_reg;

  always_ff @(posedge CLK_40) begin
    if (reset)
      hold_reg <= 1'b0;
    else
      hold_reg <= pixel_out;
  end

endmodule

// File: tb/tb_vga_scan_fetch.sv
// Randomized bench for vga_scan_fetch on a shrunken screen geometry.
// Expected pixels are queued by a step-count reference model and popped by a monitor.
module tb_vga_scan_fetch;

  localparam int H_AREA = 80;
  localparam int H_LINE = 96;
  localparam int V_AREA = 48;
  localparam int V_LINE = 52;
  localparam int SS     = 3;
  localparam int SRC_W  = 10;
  localparam int SRC_H  = 6;
  localparam int AW     = 6;
  localparam int LAT    = 2;
  localparam int XW     = $clog2(H_LINE);
  localparam int YW     = $clog2(V_LINE);
  localparam int FRAME  = H_LINE * V_LINE;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          pixel_clk = 1'b0;
  logic          frame_ready = 1'b0;
  logic          mem_rd_data;
  logic [XW-1:0] x_pos;
  logic [YW-1:0] y_pos;
  logic          frame_start, mem_rd_en, pixel_out, pixel_valid, bank_sel, frame_ack;
  logic [AW:0]   mem_addr;

  vga_scan_fetch #(
    .H_AREA(H_AREA), .H_LINE(H_LINE), .V_AREA(V_AREA), .V_LINE(V_LINE),
    .SCALE_SHIFT(SS), .SRC_W(SRC_W), .SRC_H(SRC_H), .ADDR_W(AW), .MEM_LATENCY(LAT)
  ) dut (
    .CLK_40(clk), .reset(reset), .pixel_clk(pixel_clk), .frame_ready(frame_ready),
    .mem_rd_data(mem_rd_data), .x_pos(x_pos), .y_pos(y_pos), .frame_start(frame_start),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .pixel_out(pixel_out),
    .pixel_valid(pixel_valid), .bank_sel(bank_sel), .frame_ack(frame_ack)
  );

  always #5 clk = ~clk;

  // Frame memory with LAT cycles of read latency and random contents.
  bit          mem_bits [1 << (AW + 1)];
  logic [AW:0] apipe [LAT];
  always @(posedge clk) begin
    apipe[0] <= mem_addr;
    for (int i = 1; i < LAT; i++) apipe[i] <= apipe[i-1];
  end
  assign mem_rd_data = mem_bits[apipe[LAT-1]];

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    int due;
    bit val;
  } exp_t;
  exp_t exp_q[$];

  // Reference model: position is derived from the number of enabled steps since reset.
  int nsteps = 0;
  bit mbank = 1'b0;
  always @(negedge clk) begin : model
    int mx, my, full;
    bit en, fs;
    exp_t e;
    if (reset) begin
      nsteps = 0;
      mbank  = 1'b0;
      exp_q.delete();
    end else begin
      mx = nsteps % H_LINE;
      my = (nsteps / H_LINE) % V_LINE;
      check("x_pos", longint'(x_pos), mx);
      check("y_pos", longint'(y_pos), my);
      check("bank_sel", longint'(bank_sel), longint'(mbank));
      if (pixel_clk) begin
        en   = (mx < H_AREA) && (my < V_AREA);
        fs   = (mx == H_LINE - 1) && (my == V_LINE - 1);
        full = (int'(mbank) << AW) + (my / (1 << SS)) * SRC_W + mx / (1 << SS);
        check("mem_rd_en", longint'(mem_rd_en), longint'(en));
        if (en) check("mem_addr", longint'(mem_addr), full);
        check("frame_start", longint'(frame_start), longint'(fs));
        check("frame_ack", longint'(frame_ack), longint'(fs && frame_ready));
        e.due = cyc + LAT;
        e.val = en ? mem_bits[full] : 1'b0;
        exp_q.push_back(e);
        nsteps++;
        if (fs && frame_ready) mbank = ~mbank;
      end else begin
        check("idle_rd_en", longint'(mem_rd_en), 0);
        check("idle_frame_start", longint'(frame_start), 0);
        check("idle_frame_ack", longint'(frame_ack), 0);
      end
    end
  end

  // Monitor: pops an expectation whenever the DUT presents a pixel.
  bit last_px = 1'b0;
  always @(negedge clk) begin : monitor
    exp_t e;
    if (reset) begin
      check("valid_in_reset", longint'(pixel_valid), 0);
      last_px = 1'b0;
    end else if (pixel_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_valid", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("pixel_latency", cyc, e.due);
        check("pixel_out", longint'(pixel_out), longint'(e.val));
        last_px = e.val;
      end
    end else begin
      check("pixel_hold", longint'(pixel_out), longint'(last_px));
      if (exp_q.size() > 0 && exp_q[0].due < cyc) begin
        check("missing_valid", cyc, exp_q[0].due);
        void'(exp_q.pop_front());
      end
    end
  end

  int fs_count = 0, fs_cyc = 0, ack_count = 0, max_local = 0;
  always @(negedge clk) begin
    if (!reset) begin
      if (frame_start) begin
        fs_count++;
        fs_cyc = cyc;
      end
      if (frame_ack) ack_count++;
      if (mem_rd_en && int'(mem_addr[AW-1:0]) > max_local) max_local = int'(mem_addr[AW-1:0]);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_x"}, longint'(x_pos), 0);
    check({tag, "_y"}, longint'(y_pos), 0);
    check({tag, "_frame_start"}, longint'(frame_start), 0);
    check({tag, "_rd_en"}, longint'(mem_rd_en), 0);
    check({tag, "_addr"}, longint'(mem_addr), 0);
    check({tag, "_pixel_out"}, longint'(pixel_out), 0);
    check({tag, "_pixel_valid"}, longint'(pixel_valid), 0);
    check({tag, "_bank"}, longint'(bank_sel), 0);
    check({tag, "_ack"}, longint'(frame_ack), 0);
  endtask

  initial begin
    int fs0, ack0, start;
    bit found;
    for (int i = 0; i < (1 << (AW + 1)); i++) mem_bits[i] = 1'($urandom_range(0, 1));

    repeat (3) tick();
    check_all_zero("reset");
    reset = 1'b0;

    // 1-in-4 enable: ten steps in forty cycles
    for (int i = 0; i < 40; i++) begin
      pixel_clk = (i % 4 == 0);
      tick();
    end
    check("duty_x", longint'(x_pos), 10);
    check("duty_y", longint'(y_pos), 0);

    // Full-rate frame with frame_ready high, then a frame with it low
    reset = 1'b1;
    pixel_clk = 1'b0;
    tick();
    reset = 1'b0;
    frame_ready = 1'b1;
    pixel_clk = 1'b1;
    fs0 = fs_count;
    ack0 = ack_count;
    start = cyc;
    repeat (FRAME) tick();
    check("frame1_fs_count", fs_count - fs0, 1);
    check("frame1_fs_cycle", fs_cyc - start, FRAME - 1);
    check("frame1_ack_count", ack_count - ack0, 1);
    check("frame1_bank", longint'(bank_sel), 1);
    check("frame1_wrap_x", longint'(x_pos), 0);
    check("frame1_wrap_y", longint'(y_pos), 0);
    check("max_local_addr", max_local, SRC_W * SRC_H - 1);
    frame_ready = 1'b0;
    repeat (FRAME) tick();
    check("frame2_fs_count", fs_count - fs0, 2);
    check("frame2_ack_count", ack_count - ack0, 1);
    check("frame2_bank", longint'(bank_sel), 1);

    // Random enable pattern and frame_ready
    repeat (3 * FRAME) begin
      pixel_clk = ($urandom_range(0, 3) != 0);
      frame_ready = 1'($urandom_range(0, 1));
      tick();
    end

    // Reset in the middle of the visible area
    frame_ready = 1'b0;
    pixel_clk = 1'b1;
    found = 1'b0;
    for (int i = 0; i < FRAME + 2; i++) begin
      if (int'(x_pos) == H_AREA / 2 && int'(y_pos) == V_AREA / 2) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    check("find_mid_frame", longint'(found), 1);
    reset = 1'b1;
    tick();
    check_all_zero("mid_reset");
    reset = 1'b0;
    #1;
    check("restart_rd_en", longint'(mem_rd_en), 1);
    check("restart_addr", longint'(mem_addr), 0);
    repeat (3000) tick();

    pixel_clk = 1'b0;
    repeat (LAT + 3) tick();
    check("queue_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_scan_fetch.md
Name: vga_scan_fetch

Overview:
Upstream stage of the VGA sync generators. Owns the x_pos/y_pos scan counters that feed hsync_gen/vsync_gen and fetches downscaled 1-bit video pixels from the double-buffered frame memory. Emits a black-masked pixel stream and swaps frame banks at frame boundaries when the SPI loader reports a new frame ready.

Parameters:
H_AREA, 800, visible pixels per line
H_LINE, 1056, total pixel clocks per line
V_AREA, 600, visible lines per frame
V_LINE, 628, total lines per frame
SCALE_SHIFT, 3, log2 of the upscale factor; source pixel = 8x8 screen pixels
SRC_W, 100, source frame width (H_AREA >> SCALE_SHIFT)
SRC_H, 75, source frame height (V_AREA >> SCALE_SHIFT)
ADDR_W, 13, bank-local address width, $clog2(SRC_W*SRC_H)
MEM_LATENCY, 1, CLK_40 cycles from mem_rd_en to valid mem_rd_data (1..3)

Ports:
CLK_40  in  1  system clock; all logic on its rising edge
reset  in  1  synchronous, active-high
pixel_clk  in  1  clock enable; one pixel step per high cycle
frame_ready  in  1  level from SPI loader: inactive bank holds a complete new frame
mem_rd_data  in  1  frame memory read data
x_pos  out  $clog2(H_LINE)  horizontal counter
y_pos  out  $clog2(V_LINE)  vertical counter
frame_start  out  1  one-cycle pulse when counters wrap to (0,0)
mem_rd_en  out  1  frame memory read strobe
mem_addr  out  ADDR_W+1  {bank_sel, bank-local address}
pixel_out  out  1  pixel value, 1 = white
pixel_valid  out  1  pulse aligned with pixel_out update
bank_sel  out  1  bank currently displayed
frame_ack  out  1  one-cycle pulse: frame_ready consumed, bank swapped

Behaviour:
- Reset: x_pos=0, y_pos=0, all other outputs 0. Any in-flight read is discarded; pipeline valid bits cleared.
- Counters advance only on cycles where pixel_clk=1.
- x_pos: H_LINE-1 wraps to 0; y_pos increments on that wrap.
- y_pos: V_LINE-1 wraps to 0 when x_pos also wraps.
- frame_start=1 for exactly the cycle where pixel_clk=1 and (x_pos,y_pos)=(H_LINE-1,V_LINE-1). Otherwise 0.
- Bank swap happens in the same cycle as frame_start.
  - If frame_ready=1: bank_sel toggles and frame_ack pulses for one cycle.
  - If frame_ready=0: bank_sel holds; the current frame repeats.
  - frame_ready is sampled only at frame_start. A bank never changes mid-frame.
- Fetch: on a pixel_clk cycle with x_pos<H_AREA and y_pos<V_AREA (current, pre-increment values):
  - assert mem_rd_en for one cycle;
  - mem_addr = {bank_sel, (y_pos>>SCALE_SHIFT)*SRC_W + (x_pos>>SCALE_SHIFT)}.
  - Address is formed with row-base/column registers, not a runtime multiplier; the value must equal the formula.
  - Maximum address is SRC_W*SRC_H-1 = 7499.
- The bank_sel used for the fetch at (0,0) is the post-swap value.
- Read pipeline: a MEM_LATENCY-deep shift of {valid, active} travels alongside each pixel_clk step.
  - MEM_LATENCY cycles after a pixel_clk step, pixel_valid=1 for one cycle.
  - pixel_out = mem_rd_data if that step was active, else 0 (blanking is black).
  - pixel_out holds between pulses.
- Back-to-back pixel_clk every cycle is supported at full rate with no drops.
- pixel_out for screen pixel (x,y) appears MEM_LATENCY cycles after the pixel_clk cycle where x_pos=x, y_pos=y.
- Downstream sync gens consume x_pos/y_pos directly and compensate latency themselves.

Test Plan:
- Reset then pixel_clk=1 continuous for 1056*628 cycles -> x_pos wraps at 1055 (y_pos 0->1 at cycle 1056); exactly one frame_start, at cycle 663167; counters return to (0,0).
- pixel_clk 1-in-4 duty -> counters step only on enable cycles; x_pos=10 after 40 cycles; no mem_rd_en on non-enable cycles.
- Address at (x,y) = (0,0), (7,7), (8,0), (799,599), bank_sel=0 -> mem_addr = 0, 0, 1, 7499; no mem_rd_en at x=800 or y=600.
- Memory model returning addr[0], MEM_LATENCY=2 -> pixel_out correct with 2-cycle lag; pixel_out=0 with pixel_valid=1 during blanking.
- frame_ready=1 across first frame_start, then 0 -> bank_sel 0->1 and one frame_ack at that frame_start; next frame_start no swap; mem_addr[13]=1 throughout frame 2.
- Assert reset at (x,y)=(400,300) mid-frame -> next cycle all outputs 0; no pixel_valid from pre-reset reads; fetch restarts at address 0.
